// File: rtl/nibble_sort4_if.sv
// Bundle of the serial element input and the one-hot result-register write bus
// for nibble_sort4; master is the producer/observer side, slave is the sorter.
interface nibble_sort4_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [3:0]   out_en;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_en, out_data, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_en, out_data, busy, done
  );
endinterface

// File: rtl/nibble_sort4.sv
// Collects four W-bit elements, sorts them with a fixed six-step compare-swap
// network, then writes them one per cycle into the downstream register bank.
module nibble_sort4 #(
  parameter int W      = 4,
  parameter bit ASCEND = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  nibble_sort4_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, SORT, EMIT, DONE} state_t;

  state_t       state;
  logic [1:0]   count;
  logic [1:0]   idx;
  logic [2:0]   step;
  logic [1:0]   lo;
  logic         swap;
  logic [W-1:0] elems [4];
  logic [W-1:0] swp   [4];

  // Compare-swap for the current step; equal values stay put so the sort is stable.
  always_comb begin
    case (step)
      3'd1, 3'd4: lo = 2'd1;
      3'd2:       lo = 2'd2;
      default:    lo = 2'd0;
    endcase
    swp  = elems;
    swap = ASCEND ? (elems[lo] > elems[lo + 2'd1])
                  : (elems[lo] < elems[lo + 2'd1]);
    if (swap) begin
      swp[lo]        = elems[lo + 2'd1];
      swp[lo + 2'd1] = elems[lo];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      count        <= 2'd0;
      idx          <= 2'd0;
      step         <= 3'd0;
      for (int i = 0; i < 4; i++) elems[i] <= '0;
      bus.in_ready <= 1'b1;
      bus.out_en   <= 4'b0000;
      bus.out_data <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bus.done <= 1'b0;
          if (bus.in_valid && bus.in_ready) begin
            elems[count] <= bus.in_data;
            if (count == 2'd3) begin
              state        <= SORT;
              count        <= 2'd0;
              step         <= 3'd0;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
            end else begin
              count <= count + 2'd1;
            end
          end
        end

        // The last swap feeds slot 0 straight into the first registered write.
        SORT: begin
          elems <= swp;
          if (step == 3'd5) begin
            state        <= EMIT;
            idx          <= 2'd0;
            bus.out_en   <= 4'b0001;
            bus.out_data <= swp[0];
          end else begin
            step <= step + 3'd1;
          end
        end

        EMIT: begin
          if (idx == 2'd3) begin
            state        <= DONE;
            bus.out_en   <= 4'b0000;
            bus.out_data <= '0;
            bus.done     <= 1'b1;
          end else begin
            idx          <= idx + 2'd1;
            bus.out_en   <= 4'b0001 << (idx + 2'd1);
            bus.out_data <= elems[idx + 2'd1];
          end
        end

        DONE: begin
          state        <= LOAD;
          bus.done     <= 1'b0;
          bus.busy     <= 1'b0;
          bus.in_ready <= 1'b1;
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/nibble_sort4.md
Name: nibble_sort4

Overview:
- Front-end stage of the sort datapath. Collects four W-bit values serially through a valid/ready input and sorts them internally with a fixed compare-swap sequence.
- Drives the bank of four enable-loaded result registers directly downstream: one shared data bus plus one-hot load enables, one register per cycle.
- Pulses done when all four registers have been written.

Parameters:
- W, 4, width of each element and of in_data/out_data.
- ASCEND, 1, 1 = ascending order (slot 0 smallest); 0 = descending.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds an element to load.
- in_data  input  W  element value.
- in_ready  output  1  block accepts an element this cycle.
- out_en  output  4  one-hot load enable; bit k loads downstream register k.
- out_data  output  W  value for the register selected by out_en.
- busy  output  1  high in SORT, EMIT and DONE.
- done  output  1  single-cycle pulse after the fourth register write.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state = LOAD, load count = 0, buf[0..3] = 0, step = 0, out_en = 0000, out_data = 0, busy = 0, done = 0, in_ready = 1.
- All outputs are decoded from state registers only. There is no combinational path from in_valid or in_data to any output.

States:
- LOAD
  - in_ready = 1.
  - A transfer is in_valid && in_ready at the rising edge; buf[count] <= in_data, count++.
  - in_valid low: nothing changes; gaps of any length are legal.
  - On the 4th transfer: next state SORT, step = 0, count = 0.
- SORT
  - 6 cycles, one compare-swap per cycle.
  - Pair order by step 0..5: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
  - ASCEND = 1: swap only if buf[i] > buf[i+1], unsigned. ASCEND = 0: swap only if buf[i] < buf[i+1].
  - Equal values are never swapped, so the sort is stable.
  - After step 5: next state EMIT, index = 0.
- EMIT
  - 4 cycles.
  - Cycle k: out_en = one-hot bit k, out_data = buf[k].
  - After k = 3: next state DONE.
  - Outside EMIT, out_en = 0000 and out_data = 0.
- DONE
  - 1 cycle, done = 1.
  - Next state LOAD with in_ready = 1.

Timing and boundary rules:
- Latency: if the 4th transfer happens at edge E, then:
  - SORT occupies cycles E+1..E+6.
  - out_en = 0001 in cycle E+7 and 1000 in cycle E+10.
  - done is high in cycle E+11.
  - in_ready returns high in cycle E+12.
- Back-pressure: in_ready = 0 in SORT, EMIT and DONE. in_valid is ignored there, and in_data is never sampled.
- Back-to-back frames: the first element of the next frame can transfer at edge E+12. Frame period is at least 15 cycles with no input gaps.
- Reset in any state, including mid-SORT or mid-EMIT: the next cycle shows reset values. A partially emitted frame is abandoned with no further out_en and no done pulse. A partial LOAD count is discarded.
- rst has priority over a simultaneous in_valid transfer.
- Width: comparisons are unsigned over W bits. The values all-zeros and all-ones sort correctly.

Test Plan:
- Random order, W = 4, ASCEND = 1: load 9,3,F,0 with no gaps. Expect writes 0,3,9,F on out_en 0001,0010,0100,1000 in cycles E+7..E+10, and done at E+11.
- Duplicates and already sorted: load 5,5,2,5 and expect emitted values 2,5,5,5. Load 1,2,3,4 and expect 1,2,3,4 with the same latency.
- Reverse input with ASCEND = 0: load 0,4,8,C and expect C,8,4,0. Also load F,F,F,F and expect F,F,F,F.
- Gaps and back-pressure:
  - Load 7,_,_,1,_,E,2 with in_valid low on the gaps; expect 1,2,7,E.
  - Hold in_valid = 1 with in_data = A throughout SORT and EMIT. Expect in_ready = 0, buffer unaffected, and the next frame's first transfer at E+12.
- Reset mid-operation:
  - Assert rst for 1 cycle at E+3 (mid-SORT). The next cycle must show reset values, with no out_en and no done afterwards.
  - A fresh load of 8,6,4,2 must emit 2,4,6,8.
  - Repeat with rst at E+8 (mid-EMIT). Only 0001 and 0010 are seen before the abort.
- Back-to-back frames: frame A = 3,1,2,0, then frame B = F,E,D,C starting at E+12. Expect two clean emit sequences, two single-cycle done pulses and no overlap of out_en.
